// File: rtl/cnn_fp16_pkg.sv
// Shared FP16 definitions for the CNN datapath: field widths, bias, special
// encodings and the window-size helper used by the pooling units.
package cnn_fp16_pkg;

  localparam int FP16_W      = 16;
  localparam int FP16_SIGN_W = 1;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MAN_W  = 10;
  localparam int FP16_BIAS   = 15;

  localparam logic [FP16_W-1:0]     FP16_POS_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0]     FP16_POS_INF  = 16'h7C00;
  localparam logic [FP16_W-1:0]     FP16_QNAN     = 16'h7E00;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_ONES = 5'h1F;

  // Smallest l with 2**l >= w; exact for the power-of-two windows in use.
  function automatic int log2_window(input int w);
    int l;
    l = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << i) < w) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder, round-to-nearest-even. Subnormal inputs and
// results below the normal range are flushed to signed zero.
module fp16_add
  import cnn_fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] y
);

  localparam int SIG_W = FP16_MAN_W + 1;
  localparam int EXT_W = 42;

  logic                  sa, sb;
  logic [FP16_EXP_W-1:0] ea, eb;
  logic [FP16_MAN_W-1:0] ma, mb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                  swap, subtract, r_sign;
  logic [FP16_EXP_W-1:0] e_big, e_small, e_diff;
  logic [SIG_W-1:0]      s_big, s_small;
  logic [EXT_W-1:0]      big_ext, small_ext, mag, norm;
  logic [5:0]            lead;
  logic                  round_up;
  logic [SIG_W:0]        rsig;
  logic signed [7:0]     rexp;
  logic [FP16_MAN_W-1:0] rman;

  always_comb begin
    sa = a[15];
    ea = a[14:10];
    ma = a[9:0];
    sb = b[15];
    eb = b[14:10];
    mb = b[9:0];

    a_nan  = (ea == FP16_EXP_ONES) && (ma != '0);
    b_nan  = (eb == FP16_EXP_ONES) && (mb != '0);
    a_inf  = (ea == FP16_EXP_ONES) && (ma == '0);
    b_inf  = (eb == FP16_EXP_ONES) && (mb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    swap     = {eb, mb} > {ea, ma};
    subtract = sa ^ sb;
    r_sign   = swap ? sb : sa;
    e_big    = swap ? eb : ea;
    e_small  = swap ? ea : eb;
    s_big    = {1'b1, swap ? mb : ma};
    s_small  = {1'b1, swap ? ma : mb};
    e_diff   = e_big - e_small;

    // 30 spare bits below the significand cover the largest exponent gap,
    // so the aligned sum is exact and rounding sees every discarded bit.
    big_ext   = {1'b0, s_big, 30'd0};
    small_ext = {1'b0, s_small, 30'd0} >> e_diff;
    mag       = subtract ? (big_ext - small_ext) : (big_ext + small_ext);

    lead = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    norm = mag << (6'd41 - lead);

    round_up = norm[30] & (norm[31] | (|norm[29:0]));
    rsig     = {1'b0, norm[41:31]} + {{SIG_W{1'b0}}, round_up};
    rexp     = $signed({3'b000, e_big}) + $signed({2'b00, lead}) - 8'sd40;
    rman     = rsig[FP16_MAN_W-1:0];
    if (rsig[SIG_W]) begin
      rexp = rexp + 8'sd1;
      rman = '0;
    end

    if (a_nan || b_nan || (a_inf && b_inf && subtract)) y = FP16_QNAN;
    else if (a_inf)                                      y = a;
    else if (b_inf)                                      y = b;
    else if (a_zero && b_zero)                           y = {sa & sb, 15'd0};
    else if (a_zero)                                     y = b;
    else if (b_zero)                                     y = a;
    else if (mag == '0)                                  y = FP16_POS_ZERO;
    else if (rexp >= 8'sd31)                             y = {r_sign, FP16_POS_INF[14:0]};
    else if (rexp <= 8'sd0)                              y = {r_sign, 15'd0};
    else                                                 y = {r_sign, rexp[4:0], rman};
  end

endmodule

// File: rtl/avg_pool_stream.sv
// Streaming multi-channel FP16 average pool: per-channel running sums, one
// shared adder, and a single output register emitting sum/WINDOW per window.
module avg_pool_stream
  import cnn_fp16_pkg::*;
#(
  parameter int WINDOW   = 4,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  input  logic [CH_W-1:0] in_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic [CH_W-1:0] out_ch
);

  localparam int               L        = log2_window(WINDOW);
  localparam int               CNT_W    = L;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [15:0]      acc_q [CHANNELS];
  logic [15:0]      acc_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;

  logic             accept, ch_ok, complete;
  logic [CH_W-1:0]  ch_idx;
  logic [15:0]      sum;

  // Divide by WINDOW by lowering the exponent; anything that would go
  // subnormal becomes signed zero, Inf/NaN and zeros pass through.
  function automatic logic [15:0] scale(input logic [15:0] x);
    logic [4:0] e;
    e = x[14:10];
    if (e == FP16_EXP_ONES || x[14:0] == 15'd0) scale = x;
    else if (e <= 5'(L))                        scale = {x[15], 15'd0};
    else                                        scale = {x[15], e - 5'(L), x[9:0]};
  endfunction

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1. out_valid/out_data/out_ch hold until taken; in_ready depends only
  // on the output register having room (empty, or being drained this cycle).
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign ch_ok    = (32'(in_ch) < CHANNELS);
  assign ch_idx   = ch_ok ? in_ch : '0;
  assign complete = accept & ch_ok & (cnt_q[ch_idx] == CNT_LAST);

  fp16_add u_add (
    .a (acc_q[ch_idx]),
    .b (in_data),
    .y (sum)
  );

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (accept && ch_ok) begin
      if (complete) begin
        acc_d[ch_idx] = FP16_POS_ZERO;
        cnt_d[ch_idx] = '0;
        out_valid_d   = 1'b1;
        out_data_d    = scale(sum);
        out_ch_d      = ch_idx;
      end else begin
        acc_d[ch_idx] = sum;
        cnt_d[ch_idx] = cnt_q[ch_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= FP16_POS_ZERO;
        cnt_q[c] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= FP16_POS_ZERO;
      out_ch_q    <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_avg_pool_stream.sv
// Bench for avg_pool_stream: directed vector table, multi-cycle sequences and
// random traffic checked by a real-arithmetic reference model.
module tb_avg_pool_stream;

  localparam int WINDOW   = 4;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [15:0]     in_data = '0;
  logic [CH_W-1:0] in_ch = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [15:0]     out_data;
  logic [CH_W-1:0] out_ch;

  int n_vec = 0;
  int n_err = 0;

  logic [CH_W+15:0] exp_q[$];
  logic [CH_W+15:0] exp_item;
  logic [15:0]      win_buf [CHANNELS][WINDOW];
  int               win_n [CHANNELS];

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [15:0]     data;
    logic            exp_valid;
    logic [15:0]     exp_data;
    logic [CH_W-1:0] exp_ch;
  } vec_t;
  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  avg_pool_stream #(.WINDOW(WINDOW), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_to_real(input logic [15:0] x);
    real r;
    r = (1024.0 + real'(int'(x[9:0]))) * pow2(int'(x[14:10]) - 25);
    return x[15] ? -r : r;
  endfunction

  // Nearest-even to an 11-bit significand, then clamp to the normal range.
  function automatic logic [15:0] ref_round(input real v);
    logic s;
    real  a, m, frac;
    int   e, ip;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m    = a * 1024.0;
    ip   = $rtoi(m);
    frac = m - real'(ip);
    if (frac > 0.5 || (frac == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    if (e > 15)  return {s, 15'h7C00};
    if (e < -14) return {s, 15'd0};
    return {s, 5'(e + 15), 10'(ip - 1024)};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] fa, fb;
    logic        a_inf, b_inf;
    real         v;
    if ((a[14:10] == 5'd31 && a[9:0] != 0) || (b[14:10] == 5'd31 && b[9:0] != 0)) return 16'h7E00;
    a_inf = (a[14:10] == 5'd31);
    b_inf = (b[14:10] == 5'd31);
    if (a_inf && b_inf) return (a[15] == b[15]) ? a : 16'h7E00;
    if (a_inf) return a;
    if (b_inf) return b;
    fa = (a[14:10] == 0) ? {a[15], 15'd0} : a;
    fb = (b[14:10] == 0) ? {b[15], 15'd0} : b;
    if (fa[14:0] == 0 && fb[14:0] == 0) return {fa[15] & fb[15], 15'd0};
    v = ((fa[14:0] == 0) ? 0.0 : fp_to_real(fa)) + ((fb[14:0] == 0) ? 0.0 : fp_to_real(fb));
    if (v == 0.0) return 16'h0000;
    return ref_round(v);
  endfunction

  function automatic logic [15:0] ref_scale(input logic [15:0] x);
    if (x[14:10] == 5'd31 || x[14:0] == 0) return x;
    return ref_round(fp_to_real(x) / real'(WINDOW));
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      for (int c = 0; c < CHANNELS; c++) win_n[c] = 0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_item = exp_q.pop_front();
          check("sb_result", 32'({out_ch, out_data}), 32'(exp_item));
        end
      end
      if (in_valid && in_ready && int'(in_ch) < CHANNELS) begin
        win_buf[int'(in_ch)][win_n[int'(in_ch)]] = in_data;
        win_n[int'(in_ch)]++;
        if (win_n[int'(in_ch)] == WINDOW) begin
          logic [15:0] acc;
          acc = 16'h0000;
          for (int j = 0; j < WINDOW; j++) acc = ref_add(acc, win_buf[int'(in_ch)][j]);
          exp_q.push_back({in_ch, ref_scale(acc)});
          win_n[int'(in_ch)] = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic [CH_W-1:0] ch, input logic [15:0] d,
                         input logic ev, input logic [15:0] ed, input logic [CH_W-1:0] ec);
    vec_t v;
    v.ch = ch; v.data = d; v.exp_valid = ev; v.exp_data = ed; v.exp_ch = ec;
    vecs.push_back(v);
  endtask

  task automatic apply_elem(input logic [CH_W-1:0] ch, input logic [15:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = ch; in_data = d;
    @(negedge clk);
    check("elem_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_fp16();
    int         sel;
    logic [4:0] e;
    logic [9:0] m;
    sel = $urandom_range(0, 63);
    m   = 10'($urandom_range(0, 1023));
    if (sel == 0)      e = 5'd0;
    else if (sel == 1) begin e = 5'd31; m = '0; end
    else if (sel == 2) e = 5'd31;
    else if (sel < 6)  e = 5'($urandom_range(1, 3));
    else               e = 5'($urandom_range(12, 18));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0000);
    check("rst_out_ch",    32'(out_ch),    32'd0);

    // single window, interleaved channels, boundaries, discard, RNE tie
    add_vec(0, 16'h4000, 0, 16'h0000, 0); add_vec(0, 16'h4200, 0, 16'h0000, 0);
    add_vec(0, 16'h4400, 0, 16'h0000, 0); add_vec(0, 16'h4500, 1, 16'h4300, 0);
    add_vec(0, 16'h3C00, 0, 16'h0000, 0); add_vec(1, 16'hBC00, 0, 16'h0000, 0);
    add_vec(0, 16'h4000, 0, 16'h0000, 0); add_vec(1, 16'hC000, 0, 16'h0000, 0);
    add_vec(0, 16'h4200, 0, 16'h0000, 0); add_vec(1, 16'hC200, 0, 16'h0000, 0);
    add_vec(0, 16'h4400, 1, 16'h4100, 0); add_vec(1, 16'hC400, 1, 16'hC100, 1);
    add_vec(0, 16'h0400, 0, 16'h0000, 0); add_vec(0, 16'h0000, 0, 16'h0000, 0);
    add_vec(0, 16'h0000, 0, 16'h0000, 0); add_vec(0, 16'h0000, 1, 16'h0000, 0);
    add_vec(1, 16'h7C00, 0, 16'h0000, 0); add_vec(1, 16'h3C00, 0, 16'h0000, 0);
    add_vec(1, 16'h3C00, 0, 16'h0000, 0); add_vec(1, 16'h3C00, 1, 16'h7C00, 1);
    add_vec(0, 16'h3C00, 0, 16'h0000, 0); add_vec(3, 16'h5000, 0, 16'h0000, 0);
    add_vec(0, 16'h3C00, 0, 16'h0000, 0); add_vec(0, 16'h3C00, 0, 16'h0000, 0);
    add_vec(0, 16'h3C00, 1, 16'h3C00, 0);
    add_vec(1, 16'h83FF, 0, 16'h0000, 0); add_vec(1, 16'h4400, 0, 16'h0000, 0);
    add_vec(1, 16'h4400, 0, 16'h0000, 0); add_vec(1, 16'h4400, 1, 16'h4200, 1);
    add_vec(0, 16'h3C00, 0, 16'h0000, 0); add_vec(0, 16'h1000, 0, 16'h0000, 0);
    add_vec(0, 16'h3C00, 0, 16'h0000, 0); add_vec(0, 16'h3C00, 1, 16'h3A00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_elem(vecs[i].ch, vecs[i].data);
      check("tbl_out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check("tbl_out_data", 32'(out_data), 32'(vecs[i].exp_data));
        check("tbl_out_ch",   32'(out_ch),   32'(vecs[i].exp_ch));
      end
    end

    // full rate: 16 back-to-back ch0 elements
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 0; in_data = 16'h4000; out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check("full_in_ready",  32'(in_ready),  32'd1);
      check("full_out_valid", 32'(out_valid), 32'(k > 0 && (k % 4) == 0));
      if (out_valid) check("full_out_data", 32'(out_data), 32'h4000);
      @(posedge clk); #1;
      if (k == 15) in_valid = 1'b0;
    end

    // backpressure with same-edge handshake and reload
    for (int k = 0; k < 3; k++) apply_elem(1, 16'h4400);
    apply_elem(0, 16'h3C00); apply_elem(0, 16'h4000); apply_elem(0, 16'h4200);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 0; in_data = 16'h4400;
    @(posedge clk); #1;
    out_ready = 1'b0; in_ch = 1; in_data = 16'h4800;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'h4100);
      check("bp_out_ch",    32'(out_ch),    32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_data",     32'(out_data), 32'h4100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_reload_valid", 32'(out_valid), 32'd1);
    check("bp_reload_data",  32'(out_data),  32'h4500);
    check("bp_reload_ch",    32'(out_ch),    32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // reset mid-window with a pending output
    for (int k = 0; k < 3; k++) apply_elem(1, 16'h3C00);
    apply_elem(0, 16'h4000); apply_elem(0, 16'h4200);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_ch = 1; in_data = 16'h3C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rmw_pending", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rmw_async_valid", 32'(out_valid), 32'd0);
    check("rmw_async_data",  32'(out_data),  32'h0000);
    check("rmw_async_ch",    32'(out_ch),    32'd0);
    check("rmw_async_ready", 32'(in_ready),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rmw_hold_valid", 32'(out_valid), 32'd0);
    check("rmw_hold_data",  32'(out_data),  32'h0000);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_elem(0, 16'h3C00);
      check("rmw_out_valid", 32'(out_valid), 32'(k == 3));
      if (k == 3) check("rmw_out_data", 32'(out_data), 32'h3C00);
    end

    // random traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ch     = ($urandom_range(0, 7) == 0) ? CH_W'(3) : CH_W'($urandom_range(0, 1));
      in_data   = rand_fp16();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avg_pool_stream.md
# avg_pool_stream

Streaming, multi-channel FP16 average-pooling unit for the CNN datapath. It accepts one IEEE-754 half-precision element per cycle, tagged with a channel index, and keeps a running sum per channel. Each time a channel collects WINDOW elements, it emits that channel's average. It supersedes the fixed four-input combinational average with a parametrised window and channel count, valid/ready flow control and per-channel state, and sits between the convolution/activation output and the next layer's input buffer.

## Interface
- WINDOW, 4: elements per pooling window. Power of two, 2..16.
- CHANNELS, 2: number of independent interleaved channels, 1..16.
- CH_W, $clog2(CHANNELS) (min 1): channel index width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input element present.
- in_ready  out  1  unit can accept an element this cycle.
- in_data  in  16  FP16 element.
- in_ch  in  CH_W  channel of in_data; values ≥ CHANNELS are accepted and discarded.
- out_valid  out  1  average available.
- out_ready  in  1  downstream accepts the average.
- out_data  out  16  FP16 average.
- out_ch  out  CH_W  channel of out_data.

## Operation
- Accept: in_valid & in_ready. in_ready = ~out_valid | out_ready. This is a single output register; no input-side stall other than this.
- Per channel there is an FP16 accumulator acc[c] (reset +0, 0x0000) and a counter cnt[c] (0..WINDOW-1).
- On accept with cnt[c] < WINDOW-1: acc[c] ← acc[c] + in_data; cnt[c] ← cnt[c]+1.
- On accept with cnt[c] == WINDOW-1:
  - out_data ← scale(acc[c] + in_data).
  - out_ch ← c; out_valid ← 1.
  - acc[c] ← +0; cnt[c] ← 0 (wrap).
- Addition uses the team's FP16 adder semantics (round-to-nearest-even). Subnormal inputs are flushed to signed zero before the add.
- scale(x) divides by WINDOW through exponent subtraction of L = log2(WINDOW):
  - exp = 31 (Inf/NaN): pass unchanged.
  - x = ±0: unchanged.
  - exp ≤ L: signed zero (flush, no subnormals).
  - Otherwise: exp − L, mantissa unchanged.
- Output hold: out_valid stays 1 and out_data/out_ch stay stable until out_valid & out_ready. Then out_valid drops, unless a new window completes in the same cycle, in which case the register reloads.
- Simultaneous output handshake and window completion: the new result overwrites in the same edge. No bubble, no loss.
- Discarded channel (in_ch ≥ CHANNELS): the element is consumed (in_ready honoured) and no state changes.
- No partial flush: an incomplete window persists indefinitely until completed or reset.

## Timing
- Reset values: in_ready 1 after reset release, out_valid 0, out_data 0x0000, out_ch 0. All acc = 0x0000, all cnt = 0.
- Latency: the completing element is accepted at edge t, and out_valid/out_data are valid in the cycle after edge t (1 cycle).
- Throughput: 1 element/cycle sustained while out_ready = 1. One result per WINDOW accepted elements per channel.
- Reset mid-window: all partial sums and counts are discarded and any pending output is dropped (out_valid → 0 immediately).
- The adder and scale logic are combinational within one cycle. No multicycle paths.

## Structure
- Shared package (cnn_fp16_pkg): FP16 field widths (sign 1 / exp 5 / man 10), exponent bias 15, constants for +0, +Inf, exponent all-ones, and a function computing L = log2(WINDOW).
- One sub-module: fp16_add, a combinational FP16 adder wrapping the codebase's existing floating-point adder. Only a single instance is used, since only one channel updates per cycle.
- Per-channel acc/cnt arrays, the output register and the scale logic live in avg_pool_stream.

## Test plan
- WINDOW=4, CHANNELS=2: ch0 receives 0x4000, 0x4200, 0x4400, 0x4500 -> one output 0x4300 (3.5), out_ch=0, one cycle after the 4th accept.
- Interleaved input: ch0 gets 0x3C00, 0x4000, 0x4200, 0x4400 and ch1 gets 0xBC00, 0xC000, 0xC200, 0xC400, alternating ch0/ch1 -> 0x4100 on ch0, then 0xC100 on ch1, in completion order.
- Backpressure:
  - Stimulus: out_ready=0 after the first result.
  - Required: out_valid held with data stable and in_ready=0.
  - Stimulus: raise out_ready while the next window's last element is presented.
  - Required: the handshake and the reload happen in the same cycle, and the second result appears next cycle.
- Reset mid-window: after ch0 receives 0x4000 and 0x4200, assert reset, then feed 0x3C00 ×4 -> output 0x3C00 (earlier elements absent); all outputs are at reset values during reset.
- Boundaries:
  - ch0 receives 0x0400, 0, 0, 0 -> 0x0000 (underflow flush).
  - ch1 receives 0x7C00, 0x3C00, 0x3C00, 0x3C00 -> 0x7C00.
  - in_ch = 3 with CHANNELS=2 -> consumed, no output, no state change.
- Full rate: 16 back-to-back ch0 elements of 0x4000 with out_ready=1 -> four outputs of 0x4000, one every 4 cycles, in_ready constantly 1.
